uart_peripheral: RTL and testbench
==================================

// Module: uart_peripheral
// PURPOSE
//  Memory-mapped UART responder on the single-cycle MIPS peripheral bus.
//  Serves the polling program's loads/stores at 0x40000018..0x40000020:
//  - receives operand bytes from the serial line
//  - exposes RX-ready/TX status
//  - transmits result bytes written by the CPU
//  Sits beside DataMemory; the CPU address decode routes 0x4000xxxx here.
// PARAMETERS
//  BASE_ADDR  32'h40000018  address of TXD; RXD = BASE+4, CON = BASE+8
//  BAUD_DIV   5208          clk cycles per bit (50 MHz / 9600)
// PORTS
//  clk        in   1   system clock, single clock domain
//  reset      in   1   asynchronous, active-high reset
//  MemRead    in   1   CPU load strobe
//  MemWrite   in   1   CPU store strobe
//  Address    in   32  byte address; only Address[31:2] is decoded
//  WriteData  in   32  store data; [7:0] used
//  ReadData   out  32  load data; combinational, 0 when not selected
//  uart_rx    in   1   serial input, asynchronous, idle high
//  uart_tx    out  1   serial output, idle high
// BEHAVIOUR
//  Frame: 8N1, 1 start (0), 8 data LSB first, 1 stop (1).
//  Register map:
//   TXD  BASE+0  W: starts TX of WriteData[7:0] if tx idle, else store dropped.
//                R: {24'b0, last accepted TX byte}.
//   RXD  BASE+4  R: {24'b0, rx_data}. Read clears rx_ready at the clk edge.
//                W: ignored.
//   CON  BASE+8  R: {26'b0, ovr, tx_busy, rx_ready, tx_done, 2'b0}
//                (bit5 ovr, bit4 tx_busy, bit3 rx_ready, bit2 tx_done).
//                Read clears tx_done (and ovr) at the clk edge. W: ignored.
//  Timing: ReadData valid the same cycle; side effects at the next posedge.
//  Reset values (async): uart_tx=1; TX/RX FSMs IDLE; rx_data=0; tx_byte=0;
//   all flags 0; counters 0.
//  RX path: 2-flop synchronizer on uart_rx. FSM states:
//   IDLE  -> START on sync low.
//   START -> wait BAUD_DIV/2 cycles, recheck line. Low -> DATA; high -> IDLE
//            (glitch rejected).
//   DATA  -> sample every BAUD_DIV cycles, 8 bits.
//   STOP  -> sample after BAUD_DIV cycles. Line 1 -> load rx_data, set
//            rx_ready. Line 0 (framing error) -> discard byte, flags unchanged.
//            Either way -> IDLE.
//  RX boundaries:
//   - New byte completes while rx_ready=1 -> rx_data overwritten, rx_ready
//     stays 1, ovr set (see CONFIGURATION).
//   - Completion and RXD read on the same edge -> set wins, rx_ready=1.
//  TX path: FSM states IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   Each state lasts BAUD_DIV cycles.
//   - tx_busy=1 from the edge after the accepted store until the end of STOP.
//   - tx_done set at the end of STOP.
//  TX boundaries:
//   - Store on the same edge as STOP ends -> dropped; busy still sampled 1.
//   - tx_done set and CON read on the same edge -> set wins.
//  Reset mid-frame aborts both FSMs; uart_tx returns to 1 immediately.
//  Unmapped addresses: ReadData=0, no side effects.
//  Simultaneous MemRead and MemWrite: both honoured.
// CONFIGURATION
//  UART_OVERRUN_EN defined: CON bit5 = sticky overrun flag.
//   Set when a byte completes while rx_ready=1; cleared by a CON read.
//  UART_OVERRUN_EN undefined: no overrun logic; bit5 always reads 0.
//   rx_data overwrite behaviour is unchanged.
// TESTING (benches use BAUD_DIV=16)
//  1. Assert reset mid-TX -> uart_tx=1 asynchronously; read CON -> 0x00.
//  2. Store 0x55 to 0x40000018 -> line 0,1,0,1,0,1,0,1,0,1, each bit 16 clk;
//     CON=0x10 during 160 clk; then CON=0x04; next CON read -> 0x00.
//  3. Drive frame 0xA3 on uart_rx -> CON=0x08 ~152 clk after start edge;
//     load 0x4000001C -> 0x000000A3; following CON read -> 0x00.
//  4. Store 0x11 to TXD, then 0x22 while tx_busy=1 -> only the 0x11 frame
//     appears; TXD reads 0x11.
//  5. uart_rx low for 4 clk then high -> no reception, CON stays 0x00.
//     Frame with stop bit 0 -> discarded, CON stays 0x00.
//  6. Frames 0x12 then 0x34 with no RXD read -> RXD=0x34;
//     CON=0x28 with UART_OVERRUN_EN, 0x08 without.

Source files
------------

// File: rtl/uart_peripheral_if.sv
// uart_peripheral_if: CPU peripheral bus bundle (load/store strobes, address, data) for the UART.
interface uart_peripheral_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  modport master (output MemRead, MemWrite, Address, WriteData, input ReadData);
  modport slave (input MemRead, MemWrite, Address, WriteData, output ReadData);
endinterface

// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART with TXD/RXD/CON registers at BASE_ADDR+0/4/8.
// Define UART_OVERRUN_EN to add the sticky overrun flag in CON bit5.
module uart_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h40000018,
  parameter int          BAUD_DIV  = 5208
) (
  input  logic             clk,
  input  logic             reset,
  uart_peripheral_if.slave bus,
  input  logic             uart_rx,
  output logic             uart_tx
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, tx_next, rx_state, rx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;
  logic [2:0] tx_bit, tx_bit_next, rx_bit, rx_bit_next;
  logic [7:0] tx_byte, tx_byte_next, rx_shift, rx_shift_next, rx_data;
  logic tx_done, tx_end, tx_busy, uart_tx_next;
  logic rx_ready, rx_ok, rx_meta, rx_s, ovr;
  logic sel_txd, sel_rxd, sel_con, wr_txd, rd_rxd, rd_con;
  logic unused;
  assign sel_txd = bus.Address[31:2] == BASE_ADDR[31:2];
  assign sel_rxd = bus.Address[31:2] == BASE_ADDR[31:2] + 30'd1;
  assign sel_con = bus.Address[31:2] == BASE_ADDR[31:2] + 30'd2;
  assign wr_txd = bus.MemWrite & sel_txd & (tx_state == IDLE);
  assign rd_rxd = bus.MemRead & sel_rxd;
  assign rd_con = bus.MemRead & sel_con;
  assign tx_busy = tx_state != IDLE;
  assign unused = &{1'b0, bus.WriteData[31:8], bus.Address[1:0]};
  assign bus.ReadData = sel_txd ? {24'b0, tx_byte} :
                        sel_rxd ? {24'b0, rx_data} :
                        sel_con ? {26'b0, ovr, tx_busy, rx_ready, tx_done, 2'b0} : 32'b0;
  always_comb begin
    tx_next = tx_state;
    tx_cnt_next = tx_cnt;
    tx_bit_next = tx_bit;
    tx_byte_next = tx_byte;
    tx_end = 1'b0;
    if (tx_state == IDLE) begin
      if (wr_txd) begin
        tx_next = START;
        tx_byte_next = bus.WriteData[7:0];
      end
    end else if (tx_cnt != FULL) begin
      tx_cnt_next = tx_cnt + 1'b1;
    end else begin
      tx_cnt_next = '0;
      tx_bit_next = tx_state == DATA ? tx_bit + 3'd1 : 3'd0;
      if (tx_state == START) tx_next = DATA;
      else if (tx_state == STOP) begin
        tx_next = IDLE;
        tx_end = 1'b1;
      end else if (tx_bit == 3'd7) tx_next = STOP;
    end
    // Line level follows the next state so the output is a clean flop.
    uart_tx_next = tx_next == START ? 1'b0 : tx_next == DATA ? tx_byte_next[tx_bit_next] : 1'b1;
  end
  always_comb begin
    rx_next = rx_state;
    rx_cnt_next = rx_cnt + 1'b1;
    rx_bit_next = rx_bit;
    rx_shift_next = rx_shift;
    rx_ok = 1'b0;
    if (rx_state == IDLE) begin
      rx_cnt_next = '0;
      if (!rx_s) rx_next = START;
    end else if (rx_state == START) begin
      if (rx_cnt == HALF) begin
        rx_cnt_next = '0;
        rx_bit_next = '0;
        if (rx_s) rx_next = IDLE;
        else rx_next = DATA;
      end
    end else if (rx_cnt == FULL) begin
      rx_cnt_next = '0;
      if (rx_state == DATA) begin
        rx_shift_next = {rx_s, rx_shift[7:1]};
        rx_bit_next = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_next = STOP;
      end else begin
        rx_ok = rx_s;
        rx_next = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_byte <= '0;
      tx_done <= 1'b0;
      uart_tx <= 1'b1;
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
      rx_data <= '0;
      rx_ready <= 1'b0;
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt <= tx_cnt_next;
      tx_bit <= tx_bit_next;
      tx_byte <= tx_byte_next;
      tx_done <= tx_end | (tx_done & ~rd_con);
      uart_tx <= uart_tx_next;
      rx_state <= rx_next;
      rx_cnt <= rx_cnt_next;
      rx_bit <= rx_bit_next;
      rx_shift <= rx_shift_next;
      if (rx_ok) rx_data <= rx_shift_next;
      rx_ready <= rx_ok | (rx_ready & ~rd_rxd);
      rx_meta <= uart_rx;
      rx_s <= rx_meta;
    end
  end
`ifdef UART_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr <= 1'b0;
    else ovr <= (rx_ok & rx_ready) | (ovr & ~rd_con);
  end
`else
  assign ovr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: random and directed bus/serial traffic checked every cycle against a
// frame-level model of the UART register map and serial line.
module tb_uart_peripheral;
  localparam int BD = 16;
  localparam logic [31:0] TXD = 32'h40000018, RXD = 32'h4000001C, CON = 32'h40000020;
`ifdef UART_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, uart_rx = 1'b1, uart_tx;
  uart_peripheral_if bus();
  uart_peripheral #(.BASE_ADDR(TXD), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;

  typedef struct {int c; logic [7:0] d;} rx_ev_t;
  rx_ev_t rxq[$];
  int total = 0, bad = 0, cyc = 0, tx_rem = 0;
  bit started = 1'b0;
  logic [7:0] tx_byte_m = 8'h0, rx_data_m = 8'h0;
  logic tx_done_m = 1'b0, rx_ready_m = 1'b0, ovr_m = 1'b0, m_rdy;
  logic [29:0] m_a;
  logic [31:0] addrs [8] = '{TXD, RXD, CON, 32'h4000001D, 32'h4000001A,
                             32'h40000024, 32'h40000014, 32'hC0000018};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    if (a[31:2] == TXD[31:2]) return {24'b0, tx_byte_m};
    if (a[31:2] == RXD[31:2]) return {24'b0, rx_data_m};
    if (a[31:2] == CON[31:2]) return {26'b0, ovr_m & OVR_EN, tx_rem != 0, rx_ready_m, tx_done_m, 2'b0};
    return 32'h0;
  endfunction

  function automatic logic exp_tx();
    int k;
    if (tx_rem == 0) return 1'b1;
    k = (BD * 10 - tx_rem) / BD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return tx_byte_m[k-1];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rem = 0; tx_byte_m = 8'h0; rx_data_m = 8'h0;
      tx_done_m = 1'b0; rx_ready_m = 1'b0; ovr_m = 1'b0;
      rxq.delete();
    end else begin
      cyc++;
      m_a = bus.Address[31:2];
      m_rdy = rx_ready_m;
      if (bus.MemRead && m_a == RXD[31:2]) rx_ready_m = 1'b0;
      if (bus.MemRead && m_a == CON[31:2]) begin tx_done_m = 1'b0; ovr_m = 1'b0; end
      if (tx_rem > 0) begin
        tx_rem--;
        if (tx_rem == 0) tx_done_m = 1'b1;
      end else if (bus.MemWrite && m_a == TXD[31:2]) begin
        tx_rem = BD * 10;
        tx_byte_m = bus.WriteData[7:0];
      end
      if (rxq.size() > 0 && rxq[0].c == cyc) begin
        ovr_m = ovr_m | m_rdy;
        rx_ready_m = 1'b1;
        rx_data_m = rxq[0].d;
        void'(rxq.pop_front());
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("read_data", bus.ReadData, exp_rd(bus.Address));
    chk("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx()});
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    bus.MemRead = rd; bus.MemWrite = wr; bus.Address = a; bus.WriteData = d;
    tick();
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = CON;
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
    bus.MemRead = 1'b1; bus.Address = a;
    #1 chk(name, bus.ReadData, exp);
    tick();
    bus.MemRead = 1'b0; bus.Address = CON;
  endtask

  task automatic con_is(string name, logic [31:0] exp);
    #1 chk(name, bus.ReadData, exp);
  endtask

  // Byte is visible 2 sync + 1 detect + half bit + 9 bit times after the start edge.
  task automatic send_frame(logic [7:0] d, bit stop_ok);
    logic [9:0] f;
    rx_ev_t e;
    f = {stop_ok, d, 1'b0};
    e.c = cyc + 3 + BD / 2 + 9 * BD;
    e.d = d;
    if (stop_ok) rxq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(BD);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = CON; bus.WriteData = 32'h0;
    #2 reset = 1'b1;
    tick(3);
    reset = 1'b0;
    started = 1'b1;
    con_is("con_reset", 32'h00);
    bus_op(0, 1, TXD, 32'h5A);
    tick(30);
    chk("tx_mid_frame", {31'b0, uart_tx}, 32'h0);
    #2 reset = 1'b1;
    #1 chk("tx_async_reset", {31'b0, uart_tx}, 32'h1);
    chk("con_in_reset", bus.ReadData, 32'h00);
    tick(2);
    reset = 1'b0;
    con_is("con_after_reset", 32'h00);
    rd_chk("txd_after_reset", TXD, 32'h00);
    bus_op(0, 1, TXD, 32'h55);
    pat = 10'b1010101010;
    tick(BD / 2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx55_bit%0d", i), {31'b0, uart_tx}, {31'b0, pat[i]});
      chk($sformatf("con_busy%0d", i), bus.ReadData, 32'h10);
      tick(BD);
    end
    con_is("con_tx_done", 32'h04);
    rd_chk("con_read_done", CON, 32'h04);
    con_is("con_done_cleared", 32'h00);
    bus_op(0, 1, TXD, 32'h3C);
    tick(BD * 10 - 1);
    bus_op(0, 1, TXD, 32'hC3);
    con_is("con_after_edge_store", 32'h04);
    rd_chk("txd_edge_drop", TXD, 32'h3C);
    rd_chk("con_clear2", CON, 32'h04);
    bus_op(0, 1, TXD, 32'h11);
    tick(2);
    bus_op(0, 1, TXD, 32'h22);
    tick(170);
    rd_chk("txd_busy_drop", TXD, 32'h11);
    rd_chk("con_clear3", CON, 32'h04);
    send_frame(8'hA3, 1'b1);
    con_is("con_rx_ready", 32'h08);
    rd_chk("rxd_a3", RXD, 32'hA3);
    con_is("con_rx_cleared", 32'h00);
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(30);
    con_is("con_glitch", 32'h00);
    send_frame(8'h5C, 1'b0);
    tick(40);
    con_is("con_bad_stop", 32'h00);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    con_is("con_overrun", OVR_EN ? 32'h28 : 32'h08);
    rd_chk("rxd_34", RXD, 32'h34);
    rd_chk("con_ovr_read", CON, OVR_EN ? 32'h20 : 32'h00);
    con_is("con_ovr_cleared", 32'h00);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
          tick($urandom_range(40, 90));
        end
      end
      begin
        int stop_c;
        stop_c = cyc + 2200;
        while (cyc < stop_c) begin
          case ($urandom_range(0, 9))
            0, 1, 2: bus_op(0, 1, TXD, $urandom);
            3, 4, 5, 6: bus_op(1, 0, addrs[$urandom_range(0, 2)], 32'h0);
            7: bus_op(1, 0, addrs[$urandom_range(3, 7)], 32'h0);
            8: bus_op(0, 1, $urandom_range(0, 1) != 0 ? RXD : CON, $urandom);
            default: bus_op(1, 1, TXD, $urandom);
          endcase
          bus.Address = addrs[$urandom_range(0, 7)];
          tick($urandom_range(0, 5));
        end
        bus.Address = CON;
      end
    join
    tick(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
